// File: rtl/cpu_run_ctrl_if.sv
// Program-load stream and instruction-memory write port of the run controller.
// The slave side is the controller; the master side is the program source
// that also observes the memory writes.
interface cpu_run_ctrl_if #(
  parameter int IW = 16,
  parameter int AW = 8
);
  logic          prog_valid;
  logic          prog_last;
  logic [IW-1:0] prog_data;
  logic          prog_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;

  modport master (
    output prog_valid, prog_last, prog_data,
    input  prog_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  prog_valid, prog_last, prog_data,
    output prog_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the multi-cycle 16-bit CPU: loads a program into
// instruction memory, releases the CPU from reset, runs it until HALT or
// timeout, then compares the debug register against an expected value.
// Optional build macro RUN_CTRL_STALL_DET_EN adds a 'stall' output and ends
// RUN early when pc stays fixed for 2*TIMEOUT/16 consecutive cycles.
module cpu_run_ctrl #(
  parameter int          IW         = 16,
  parameter int          DW         = 16,
  parameter int          AW         = 8,
  parameter int          PROG_DEPTH = 16,
  parameter logic [3:0]  HALT_OP    = 4'hF,
  parameter int          DRAIN      = 2,
  parameter int          TIMEOUT    = 1024,
  parameter int          CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  cpu_run_ctrl_if.slave prog_if,
  input  logic [DW-1:0] expected,
  output logic          cpu_rst,
  output logic          cpu_en,
  input  logic [AW-1:0] pc,
  input  logic [IW-1:0] instr,
  input  logic [DW-1:0] dbg_reg,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
`ifdef RUN_CTRL_STALL_DET_EN
  output logic          stall,
`endif
  output logic [CW-1:0] cycles
);

  // Load counter must be able to hold PROG_DEPTH itself.
  localparam int CNT_W = AW + 1;
  // DRAIN is expected to be at least 1.
  localparam int DRN_W = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4,
    S_CHECK   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic [DW-1:0]  exp_q, exp_d;
  logic           imem_we_q, imem_we_d;
  logic [AW-1:0]  imem_addr_q, imem_addr_d;
  logic [IW-1:0]  imem_wdata_q, imem_wdata_d;
  logic           prog_ready_q, prog_ready_d;
  logic           cpu_rst_q, cpu_rst_d;
  logic           cpu_en_q, cpu_en_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic           timeout_q, timeout_d;
  logic [CW-1:0]  cycles_q, cycles_d;

  logic           accept_s;
  logic           halt_s;
  logic [CW-1:0]  cycles_inc_s;

`ifdef RUN_CTRL_STALL_DET_EN
  localparam int STALL_LIM = 2 * TIMEOUT / 16;
  logic [AW-1:0]  pc_last_q, pc_last_d;
  logic [CW-1:0]  same_q, same_d;
  logic           stall_q, stall_d;
  logic           stall_hit_s;
`else
  logic           unused_pc_s;
  assign unused_pc_s = ^{pc, instr[IW-5:0]};
`endif

  assign accept_s     = (state_q == S_LOAD) && prog_ready_q && prog_if.prog_valid;
  assign halt_s       = (instr[IW-1:IW-4] == HALT_OP);
  assign cycles_inc_s = (cycles_q == {CW{1'b1}}) ? cycles_q : (cycles_q + CW'(1));

`ifdef RUN_CTRL_STALL_DET_EN
  // Track how long pc has been sitting on one value while running.
  always_comb begin
    pc_last_d   = pc;
    same_d      = {CW{1'b0}};
    stall_hit_s = 1'b0;
    if (state_q == S_RUN) begin
      if (pc == pc_last_q) begin
        same_d      = (same_q == {CW{1'b1}}) ? same_q : (same_q + CW'(1));
        stall_hit_s = (same_q >= CW'(STALL_LIM - 2));
      end else begin
        same_d      = {CW{1'b0}};
        stall_hit_s = 1'b0;
      end
    end else begin
      same_d      = {CW{1'b0}};
      stall_hit_s = 1'b0;
    end
  end
`endif

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drn_d        = drn_q;
    exp_d        = exp_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    cycles_d     = cycles_q;
`ifdef RUN_CTRL_STALL_DET_EN
    stall_d      = stall_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          exp_d     = expected;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          cycles_d  = {CW{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
`ifdef RUN_CTRL_STALL_DET_EN
          stall_d   = 1'b0;
`endif
          state_d   = S_LOAD;
        end else begin
          state_d   = state_q;
        end
      end
      S_LOAD: begin
        if (accept_s) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = cnt_q[AW-1:0];
          imem_wdata_d = prog_if.prog_data;
          cnt_d        = cnt_q + CNT_W'(1);
          if (prog_if.prog_last || (cnt_q == CNT_W'(PROG_DEPTH - 1))) begin
            state_d = S_RELEASE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RELEASE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        cycles_d = cycles_inc_s;
        if (halt_s) begin
          drn_d   = {DRN_W{1'b0}};
          state_d = S_DRAIN;
        end else if (cycles_q == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
`ifdef RUN_CTRL_STALL_DET_EN
        end else if (stall_hit_s) begin
          timeout_d = 1'b1;
          stall_d   = 1'b1;
          state_d   = S_DONE;
`endif
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        cycles_d = cycles_inc_s;
        if (drn_q == DRN_W'(DRAIN - 1)) begin
          state_d = S_CHECK;
        end else begin
          drn_d   = drn_q + DRN_W'(1);
          state_d = S_DRAIN;
        end
      end
      S_CHECK: begin
        pass_d  = (dbg_reg == exp_q);
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs follow the state being entered so they are registered.
    prog_ready_d = (state_d == S_LOAD);
    cpu_rst_d    = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_RELEASE);
    cpu_en_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
    busy_d       = (state_d == S_LOAD) || (state_d == S_RELEASE) || (state_d == S_RUN) ||
                   (state_d == S_DRAIN) || (state_d == S_CHECK);
    done_d       = (state_d == S_DONE);
  end

  // State and output registers; reset drives every output to its idle value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      drn_q        <= {DRN_W{1'b0}};
      exp_q        <= {DW{1'b0}};
      imem_we_q    <= 1'b0;
      imem_addr_q  <= {AW{1'b0}};
      imem_wdata_q <= {IW{1'b0}};
      prog_ready_q <= 1'b0;
      cpu_rst_q    <= 1'b1;
      cpu_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cycles_q     <= {CW{1'b0}};
`ifdef RUN_CTRL_STALL_DET_EN
      pc_last_q    <= {AW{1'b0}};
      same_q       <= {CW{1'b0}};
      stall_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drn_q        <= drn_d;
      exp_q        <= exp_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      prog_ready_q <= prog_ready_d;
      cpu_rst_q    <= cpu_rst_d;
      cpu_en_q     <= cpu_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      cycles_q     <= cycles_d;
`ifdef RUN_CTRL_STALL_DET_EN
      pc_last_q    <= pc_last_d;
      same_q       <= same_d;
      stall_q      <= stall_d;
`endif
    end
  end

  assign prog_if.prog_ready = prog_ready_q;
  assign prog_if.imem_we    = imem_we_q;
  assign prog_if.imem_addr  = imem_addr_q;
  assign prog_if.imem_wdata = imem_wdata_q;
  assign cpu_rst            = cpu_rst_q;
  assign cpu_en             = cpu_en_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign timeout            = timeout_q;
  assign cycles             = cycles_q;
`ifdef RUN_CTRL_STALL_DET_EN
  assign stall              = stall_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a toy CPU fetches from a memory filled by the
// controller's write strobes; outcomes are predicted from the program text.
module tb_cpu_run_ctrl;
  localparam int IW = 16, DW = 16, AW = 8, PROG_DEPTH = 4, DRAIN = 2, TIMEOUT = 64, CW = 16;

  typedef logic [15:0] wq_t[$];

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [DW-1:0] expected = '0;
  logic cpu_rst, cpu_en, busy, done, pass, timeout;
  logic [CW-1:0] cycles;
  logic [AW-1:0] pc = '0;
  logic [IW-1:0] instr = '0;
  logic [DW-1:0] dbg_reg = '0;
`ifdef RUN_CTRL_STALL_DET_EN
  logic stall;
`endif

  cpu_run_ctrl_if #(.IW(IW), .AW(AW)) pif ();

  cpu_run_ctrl #(.IW(IW), .DW(DW), .AW(AW), .PROG_DEPTH(PROG_DEPTH), .HALT_OP(4'hF),
                 .DRAIN(DRAIN), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_if(pif), .expected(expected),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .pc(pc), .instr(instr), .dbg_reg(dbg_reg),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
`ifdef RUN_CTRL_STALL_DET_EN
    .stall(stall),
`endif
    .cycles(cycles));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_cyc = -1;
  int fall_cyc = -1;
  logic prev_rst = 1'b1;
  logic [31:0] wr_q[$];
  logic [31:0] wr_exp[$];
  logic [15:0] cpu_mem [256];
  logic [15:0] model_mem [256];

  // Toy CPU: opcode 0 adds its low byte to dbg_reg, opcode F halts, others are no-ops.
  always @(posedge clk) begin
    if (pif.imem_we) cpu_mem[pif.imem_addr] <= pif.imem_wdata;
    cyc <= cyc + 1;
    if (cpu_rst) begin
      pc <= '0; instr <= '0; dbg_reg <= '0;
    end else if (cpu_en && instr[15:12] != 4'hF) begin
      instr <= cpu_mem[pc];
      pc <= pc + 8'd1;
      if (cpu_mem[pc][15:12] == 4'h0) dbg_reg <= dbg_reg + {8'h00, cpu_mem[pc][7:0]};
    end
  end

  // Observe writes, handshakes and the cpu_rst release between edges.
  always @(negedge clk) begin
    if (pif.imem_we) wr_q.push_back({8'h00, pif.imem_addr, pif.imem_wdata});
    if (pif.prog_valid && pif.prog_ready) hs_cyc = cyc;
    if (prev_rst && !cpu_rst) fall_cyc = cyc;
    prev_rst = cpu_rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
    chk({tag, "_we"}, 32'(pif.imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(pif.imem_addr), 32'd0);
    chk({tag, "_ready"}, 32'(pif.prog_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_cycles"}, 32'(cycles), 32'd0);
  endtask

  // Expected writes: words in order until prog_last or PROG_DEPTH words.
  task automatic model_load(input wq_t words, input int last_pos);
    wr_exp.delete();
    for (int i = 0; i < words.size(); i++) begin
      if (i >= PROG_DEPTH) break;
      wr_exp.push_back({8'h00, 8'(i), words[i]});
      model_mem[i] = words[i];
      if (i == last_pos) break;
    end
  endtask

  task automatic load_prog(input wq_t words, input int last_pos, input bit gaps);
    bit got;
    for (int i = 0; i < words.size(); i++) begin
      if (gaps) begin
        pif.prog_valid = 1'b0;
        @(posedge clk); #1;
      end
      pif.prog_valid = 1'b1;
      pif.prog_data = words[i];
      pif.prog_last = (i == last_pos);
      got = 1'b0;
      for (int w = 0; w < 6; w++) begin
        @(negedge clk);
        if (pif.prog_ready) begin got = 1'b1; break; end
      end
      if (!got) break;
      @(posedge clk); #1;
    end
    pif.prog_valid = 1'b0;
    pif.prog_last = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] exp_v);
    @(posedge clk); #1;
    start = 1'b1; expected = exp_v;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // exp_mode: 0 = use exp_given, 1 = predicted dbg value, 2 = predicted value with bit 0 flipped.
  task automatic do_run(input wq_t words, input int last_pos, input bit gaps, input int exp_mode,
                        input logic [15:0] exp_given, input bit mid_start, input string tag);
    int k;
    logic [15:0] dbg_m;
    logic [15:0] exp_v;
    bit halted;
    model_load(words, last_pos);
    k = 0; dbg_m = '0;
    while (k <= TIMEOUT - 2 && model_mem[k][15:12] != 4'hF) begin
      if (model_mem[k][15:12] == 4'h0) dbg_m = dbg_m + {8'h00, model_mem[k][7:0]};
      k++;
    end
    halted = (k <= TIMEOUT - 2);
    exp_v = (exp_mode == 0) ? exp_given : ((exp_mode == 1) ? dbg_m : (dbg_m ^ 16'h0001));
    wr_q.delete(); hs_cyc = -1; fall_cyc = -1;
    pulse_start(exp_v);
    chk({tag, "_st_busy"}, 32'(busy), 32'd1);
    chk({tag, "_st_done"}, 32'(done), 32'd0);
    chk({tag, "_st_pass"}, 32'(pass), 32'd0);
    chk({tag, "_st_tmo"}, 32'(timeout), 32'd0);
    chk({tag, "_st_cyc"}, 32'(cycles), 32'd0);
    load_prog(words, last_pos, gaps);
    if (mid_start) begin
      for (int i = 0; i < 60; i++) begin @(negedge clk); if (cpu_en) break; end
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk({tag, "_ign_busy"}, 32'(busy), 32'd1);
      chk({tag, "_ign_en"}, 32'(cpu_en), 32'd1);
    end
    for (int i = 0; i < 400; i++) begin @(negedge clk); if (done) break; end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(wr_exp.size()));
    for (int i = 0; i < wr_exp.size() && i < wr_q.size(); i++)
      chk({tag, "_wr"}, wr_q[i], wr_exp[i]);
    chk({tag, "_rstfall"}, 32'(fall_cyc - hs_cyc), 32'd2);
    chk({tag, "_pass"}, 32'(pass), 32'(halted && (exp_v == dbg_m)));
    chk({tag, "_tmo"}, 32'(timeout), 32'(!halted));
    chk({tag, "_cycles"}, 32'(cycles), halted ? 32'(k + 2 + DRAIN) : 32'(TIMEOUT));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_en"}, 32'(cpu_en), 32'd0);
    chk({tag, "_cpurst"}, 32'(cpu_rst), 32'd0);
  endtask

  initial begin
    wq_t p_add, p_six, p_four, p_rnd;
    for (int i = 0; i < 256; i++) begin cpu_mem[i] = '0; model_mem[i] = '0; end
    pif.prog_valid = 1'b0; pif.prog_last = 1'b0; pif.prog_data = '0;
    p_add  = '{16'h0201, 16'h0401, 16'h8650, 16'hF000};
    p_six  = '{16'h0201, 16'h0201, 16'h0201, 16'h0201, 16'h0201, 16'h0201};
    p_four = '{16'h0201, 16'h0201, 16'h0201, 16'h0201};

    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    reset = 1'b1;

    do_run(p_add, 3, 1'b1, 0, 16'd2, 1'b0, "add_ok");
    do_run(p_add, 3, 1'b0, 0, 16'd3, 1'b0, "add_bad");
    do_run(p_six, -1, 1'b0, 0, 16'd0, 1'b0, "timeout");
    do_run(p_four, -1, 1'b1, 0, 16'd0, 1'b1, "start_in_run");

    // Reset during RUN, then rerun the adding program.
    model_load(p_four, -1);
    pulse_start(16'd0);
    load_prog(p_four, -1, 1'b0);
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (cpu_en) break; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk_reset("midrun_rst");
    @(posedge clk); #1 reset = 1'b1;
    do_run(p_add, 3, 1'b0, 0, 16'd2, 1'b0, "after_rst");

    for (int r = 0; r < 8; r++) begin
      int n, lp, sel;
      p_rnd.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        sel = $urandom_range(0, 9);
        if (sel < 5)      p_rnd.push_back({8'h00, 8'($urandom_range(0, 255))});
        else if (sel < 8) p_rnd.push_back({4'h8, 12'($urandom_range(0, 4095))});
        else              p_rnd.push_back({4'hF, 12'($urandom_range(0, 4095))});
      end
      lp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      do_run(p_rnd, lp, 1'($urandom_range(0, 1)), $urandom_range(1, 2), 16'd0, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesizable run controller for the multi-cycle 16-bit CPU. It replaces hand-poked testbench sequencing with a parametrised hardware harness. It loads a program into instruction memory through a valid/ready stream, then releases the CPU from reset and runs it. It detects HALT or a timeout, compares the debug register against an expected value, and reports pass/fail with a cycle count.

Parameters:
IW, 16, instruction word width
DW, 16, debug/result register width
AW, 8, instruction memory address width (matches pc width)
PROG_DEPTH, 16, max program words loaded (≤ 2**AW)
HALT_OP, 4'hF, opcode in instr[IW-1:IW-4] treated as HALT
DRAIN, 2, cycles waited after HALT seen before sampling dbg_reg
TIMEOUT, 1024, max RUN cycles before abort
CW, 16, cycle counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins LOAD when idle
prog_valid  in  1  program word valid
prog_last  in  1  marks final program word
prog_data  in  IW  program word
prog_ready  out  1  controller accepts word
expected  in  DW  expected dbg_reg value; sampled on start
cpu_rst  out  1  active-high reset to cpu_datapath
cpu_en  out  1  cpu enable
imem_we  out  1  instruction memory write strobe
imem_addr  out  AW  write address
imem_wdata  out  IW  write data
pc  in  AW  cpu pc_out
instr  in  IW  cpu current instruction register
dbg_reg  in  DW  cpu dbg_reg_out
busy  out  1  high in LOAD/RELEASE/RUN/DRAIN/CHECK
done  out  1  sticky completion flag
pass  out  1  valid when done
timeout  out  1  valid when done
cycles  out  CW  RUN cycles elapsed, saturating

Behaviour:
- Reset (reset=0, async): state=IDLE, cpu_rst=1, cpu_en=0, imem_we=0, imem_addr=0, prog_ready=0, busy=0, done=0, pass=0, timeout=0, cycles=0.
- IDLE: cpu_rst=1. On start: latch expected, clear done/pass/timeout/cycles/load count, go to LOAD. start in any other state is ignored.
- LOAD: prog_ready=1 and cpu_rst=1.
  - Each prog_valid&prog_ready cycle: imem_we=1, imem_addr=count, imem_wdata=prog_data (all registered, one write per cycle), count++.
  - Exit to RELEASE after the accepted word carrying prog_last, or after the PROG_DEPTH-th word, whichever comes first.
  - prog_ready drops the cycle after exit. Gaps in prog_valid are allowed.
- RELEASE: one cycle with imem_we=0 and cpu_rst=1; next cycle cpu_rst=0. Go to RUN.
- RUN: cpu_en=1; cycles increments every cycle, saturating at 2**CW-1.
  - If instr[IW-1:IW-4]==HALT_OP, go to DRAIN.
  - Else if cycles==TIMEOUT-1, set timeout=1 and go to DONE.
  - If both occur on the same cycle, HALT wins.
- DRAIN: cpu_en=1 for DRAIN cycles (counter); cycles keeps counting. Go to CHECK.
- CHECK: cpu_en=0; pass = (dbg_reg == expected_latched). Go to DONE.
- DONE: done=1, busy=0, cpu_en=0. cpu_rst stays 0 so CPU state remains observable. start returns to LOAD (clearing flags; cpu_rst reasserted).
- Reset mid-operation: immediate return to reset values; a partially loaded program is not rewritten.
- pass=0 whenever timeout=1.
- All outputs are registered.

Optional Feature:
RUN_CTRL_STALL_DET_EN
- Defined: in RUN, if pc holds the same value for 2*TIMEOUT/16 consecutive cycles without HALT, go to DONE with timeout=1 and an extra output stall (1 bit) = 1. This catches branch-to-self loops early.
- Undefined: no stall port; only HALT or TIMEOUT ends RUN.

Test Plan:
- Load 0201, 0401, 8650, F000 (last on 4th word), expected=2, start → imem writes at addr 0..3; cpu_rst falls 2 cycles after load; done=1, pass=1, timeout=0, cycles<TIMEOUT.
- Same program, expected=3 → done=1, pass=0, timeout=0.
- TIMEOUT=64, program 0201 repeated PROG_DEPTH times with no HALT and rest of memory non-HALT → done=1, timeout=1, pass=0, cycles=64.
- LOAD with prog_valid toggling every other cycle, 4 words → exactly 4 imem_we pulses at addr 0,1,2,3; no duplicate or dropped words. Also PROG_DEPTH=4 with 6 words offered and no prog_last → only 4 accepted.
- Assert reset=0 for 1 cycle during RUN → cpu_rst=1, cpu_en=0, busy=0, done=0 immediately. A new start reruns the 1+1 program to pass=1.
- Pulse start during RUN → ignored, cycles unaffected. Pulse start in DONE → flags clear and LOAD re-entered.
